// File: rtl/alu_acc_seq_pkg.sv
// Shared definitions for the accumulator ALU sequencer: data width, op
// encodings and FSM state type.
package alu_acc_seq_pkg;

   localparam int DATA_W = 16;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_16b.sv
// Combinational 16-bit ALU producing a 17-bit result; bit 16 is carry for
// add, borrow for sub and zero for logic ops. Unused op codes behave as add.
module alu_16b
   import alu_acc_seq_pkg::*;
(
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W:0]   res_o
);

   logic [DATA_W:0] a_ext;
   logic [DATA_W:0] b_ext;

   assign a_ext = {1'b0, a_i};
   assign b_ext = {1'b0, b_i};

   // NOTE: res_o is assigned on every path (default arm included) so no latch is inferred.
   always_comb begin
      res_o = a_ext + b_ext;
      case (op_i)
         OP_SUB:  res_o = a_ext - b_ext;
         OP_AND:  res_o = a_ext & b_ext;
         OP_OR:   res_o = a_ext | b_ext;
         OP_XOR:  res_o = a_ext ^ b_ext;
         default: res_o = a_ext + b_ext;
      endcase
   end

endmodule

// File: rtl/alu_acc_seq.sv
// Command/result sequencer around alu_16b with an accumulator that can feed
// operand A. One command in flight: IDLE -> EXEC -> DONE -> IDLE.
module alu_acc_seq
   import alu_acc_seq_pkg::*;
#(
   parameter logic [DATA_W-1:0] ACC_INIT = 16'h0000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [2:0]        cmd_op_i,
   input  logic [DATA_W-1:0] cmd_a_i,
   input  logic [DATA_W-1:0] cmd_b_i,
   input  logic              cmd_acc_i,
   input  logic              acc_clr_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [DATA_W-1:0] res_data_o,
   output logic              res_carry_o,
   output logic              res_zero_o,
   output logic              res_neg_o,
   output logic [DATA_W-1:0] acc_o,
   output logic              busy_o
);

   state_e            state_q, state_d;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] res_q;
   logic              carry_q, zero_q, neg_q;
   logic [DATA_W:0]   alu_res;
   logic              accept;

   assign accept = (state_q == ST_IDLE) && cmd_valid_i;

   alu_16b u_alu (
      .op_i  (op_q),
      .a_i   (a_q),
      .b_i   (b_q),
      .res_o (alu_res)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cmd_valid_i) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_DONE;
         ST_DONE: if (res_ready_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: operand registers carry no reset; they are only read in EXEC, after a capture.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         op_q <= cmd_op_i;
         a_q  <= cmd_acc_i ? acc_q : cmd_a_i;
         b_q  <= cmd_b_i;
      end
   end

   // Clear beats the EXEC write; reset beats both.
   always_ff @(posedge clk_i) begin
      if (rst_i)                   acc_q <= ACC_INIT;
      else if (acc_clr_i)          acc_q <= ACC_INIT;
      else if (state_q == ST_EXEC) acc_q <= alu_res[DATA_W-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         res_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else if (state_q == ST_EXEC) begin
         res_q   <= alu_res[DATA_W-1:0];
         carry_q <= alu_res[DATA_W];
         zero_q  <= (alu_res[DATA_W-1:0] == '0);
         neg_q   <= alu_res[DATA_W-1];
      end
   end

   assign cmd_ready_o = (state_q == ST_IDLE);
   assign res_valid_o = (state_q == ST_DONE);
   assign busy_o      = (state_q != ST_IDLE);
   assign res_data_o  = res_q;
   assign res_carry_o = carry_q;
   assign res_zero_o  = zero_q;
   assign res_neg_o   = neg_q;
   assign acc_o       = acc_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboard bench for alu_acc_seq: expected results are queued at command
// issue and compared when res_valid_o appears.
module tb_alu_acc_seq;
   import alu_acc_seq_pkg::*;

   localparam logic [15:0] ACC_INIT_TB = 16'h0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [2:0]  cmd_op_i;
   logic [15:0] cmd_a_i;
   logic [15:0] cmd_b_i;
   logic        cmd_acc_i;
   logic        acc_clr_i;
   logic        res_valid_o;
   logic        res_ready_i;
   logic [15:0] res_data_o;
   logic        res_carry_o;
   logic        res_zero_o;
   logic        res_neg_o;
   logic [15:0] acc_o;
   logic        busy_o;

   always #5 clk_i = ~clk_i;

   alu_acc_seq #(.ACC_INIT(ACC_INIT_TB)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_op_i    (cmd_op_i),
      .cmd_a_i     (cmd_a_i),
      .cmd_b_i     (cmd_b_i),
      .cmd_acc_i   (cmd_acc_i),
      .acc_clr_i   (acc_clr_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_data_o  (res_data_o),
      .res_carry_o (res_carry_o),
      .res_zero_o  (res_zero_o),
      .res_neg_o   (res_neg_o),
      .acc_o       (acc_o),
      .busy_o      (busy_o)
   );

   typedef struct packed {
      logic [15:0] data;
      logic        carry;
      logic        zero;
      logic        neg;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_acc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] ea;
      logic [16:0] eb;
      ea = {1'b0, a};
      eb = {1'b0, b};
      case (op)
         3'b001:  return ea - eb;
         3'b010:  return ea & eb;
         3'b011:  return ea | eb;
         3'b100:  return ea ^ eb;
         default: return ea + eb;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic accm, input logic clr);
      logic [16:0] r;
      exp_t        e;
      int          n;
      n = 0;
      while (!cmd_ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check("ready_wait", 32'(cmd_ready_o), 32'd1);
      r = model(op, accm ? m_acc : a, b);
      e.data  = r[15:0];
      e.carry = r[16];
      e.zero  = (r[15:0] == 16'h0000);
      e.neg   = r[15];
      sb_q.push_back(e);
      m_acc = r[15:0];
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_a_i     = a;
      cmd_b_i     = b;
      cmd_acc_i   = accm;
      acc_clr_i   = clr;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      acc_clr_i   = 1'b0;
      check("exec_no_valid", 32'(res_valid_o), 32'd0);
      check("exec_busy", 32'(busy_o), 32'd1);
      if (clr) check("acc_clr_idle", 32'(acc_o), 32'(ACC_INIT_TB));
   endtask

   // Waits for a result (exp_wait = negedges expected before valid), checks it,
   // stalls for 'hold' cycles with a spurious command, then handshakes.
   task automatic collect(input int exp_wait, input int hold);
      exp_t e;
      int   n;
      n = 0;
      while (!res_valid_o && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      check("valid_seen", 32'(res_valid_o), 32'd1);
      check("latency", 32'(n), 32'(exp_wait));
      check("sb_nonempty", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check("data",  32'(res_data_o),  32'(e.data));
         check("carry", 32'(res_carry_o), 32'(e.carry));
         check("zero",  32'(res_zero_o),  32'(e.zero));
         check("neg",   32'(res_neg_o),   32'(e.neg));
         check("acc",   32'(acc_o),       32'(m_acc));
         for (int i = 0; i < hold; i++) begin
            cmd_valid_i = 1'b1;
            cmd_a_i     = 16'($urandom);
            cmd_b_i     = 16'($urandom);
            @(negedge clk_i);
            check("hold_valid", 32'(res_valid_o), 32'd1);
            check("hold_data",  32'(res_data_o),  32'(e.data));
            check("hold_ready", 32'(cmd_ready_o), 32'd0);
         end
      end
      cmd_valid_i = 1'b0;
      res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
      check("back_idle", 32'(busy_o), 32'd0);
      check("no_valid_idle", 32'(res_valid_o), 32'd0);
   endtask

   initial begin
      rst_i       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_op_i    = 3'b000;
      cmd_a_i     = 16'h0000;
      cmd_b_i     = 16'h0000;
      cmd_acc_i   = 1'b0;
      acc_clr_i   = 1'b0;
      res_ready_i = 1'b0;
      m_acc       = ACC_INIT_TB;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      check("rst_ready", 32'(cmd_ready_o), 32'd1);
      check("rst_busy",  32'(busy_o),      32'd0);
      check("rst_valid", 32'(res_valid_o), 32'd0);
      check("rst_acc",   32'(acc_o),       32'(ACC_INIT_TB));
      check("rst_data",  32'(res_data_o),  32'd0);
      check("rst_flags", 32'({res_carry_o, res_zero_o, res_neg_o}), 32'd0);

      // add wrap: 0 with carry, zero flag
      send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      collect(1, 0);
      // sub with borrow, then accumulator-sourced xor
      send(OP_SUB, 16'h0003, 16'h0005, 1'b0, 1'b0);
      collect(1, 0);
      send(OP_XOR, 16'hAAAA, 16'hFFFF, 1'b1, 1'b0);
      collect(1, 5);
      check("xor_acc_result", 32'(acc_o), 32'h0001);

      // clear during EXEC: acc cleared, result still the computed sum
      send(OP_ADD, 16'h1234, 16'h1111, 1'b0, 1'b0);
      acc_clr_i = 1'b1;
      @(negedge clk_i);
      acc_clr_i = 1'b0;
      m_acc = ACC_INIT_TB;
      check("clr_exec_acc", 32'(acc_o), 32'(ACC_INIT_TB));
      collect(0, 0);
      check("clr_exec_data", 32'(res_data_o), 32'h2345);

      // clear coincident with acc-mode accept: A uses pre-clear accumulator
      send(OP_ADD, 16'h0100, 16'h0000, 1'b0, 1'b0);
      collect(1, 0);
      send(OP_OR, 16'h5555, 16'h0001, 1'b1, 1'b1);
      collect(1, 0);
      check("clr_idle_result", 32'(res_data_o), 32'h0101);

      // reset during EXEC drops the in-flight result
      cmd_valid_i = 1'b1;
      cmd_op_i    = OP_ADD;
      cmd_a_i     = 16'h0F0F;
      cmd_b_i     = 16'h0101;
      cmd_acc_i   = 1'b0;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      check("rst_exec_busy", 32'(busy_o), 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      m_acc = ACC_INIT_TB;
      check("rst_exec_ready", 32'(cmd_ready_o), 32'd1);
      check("rst_exec_acc",   32'(acc_o),       32'(ACC_INIT_TB));
      for (int i = 0; i < 3; i++) begin
         check("rst_exec_novalid", 32'(res_valid_o), 32'd0);
         @(negedge clk_i);
      end

      // reserved op code behaves as add
      send(3'b110, 16'h0010, 16'h0020, 1'b0, 1'b0);
      collect(1, 0);
      check("op110_data", 32'(res_data_o), 32'h0030);

      for (int k = 0; k < 10; k++) begin
         send(3'($urandom_range(7)), 16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'b0);
         collect(1, $urandom_range(2));
      end

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
